// File: rtl/fuel_alert_controller_if.sv
// Bundles the fuel-gauge sample stream, driver acknowledge and the alert outputs
// of fuel_alert_controller into one connection.
interface fuel_alert_controller_if;
   logic       sample_valid;
   logic [4:0] remaining_fuel;
   logic       ack;
   logic [1:0] state;
   logic       warn_led;
   logic       crit_led;
   logic       buzzer;
   logic [7:0] alert_count;

   modport master (
      output sample_valid, remaining_fuel, ack,
      input  state, warn_led, crit_led, buzzer, alert_count
   );

   modport slave (
      input  sample_valid, remaining_fuel, ack,
      output state, warn_led, crit_led, buzzer, alert_count
   );
endinterface

// File: rtl/fuel_alert_controller.sv
// Debounced, hysteretic fuel-level alerting: four severity levels, warning and
// critical LEDs (blinking when empty), an acknowledgeable buzzer and an entry counter.
module fuel_alert_controller #(
   parameter int unsigned LOW_LEVEL  = 5,
   parameter int unsigned CRIT_LEVEL = 2,
   parameter int unsigned HYST       = 1,
   parameter int unsigned DEBOUNCE   = 4,
   parameter int unsigned BLINK_HALF = 8
) (
   input logic                     clk,
   input logic                     reset,
   fuel_alert_controller_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_NORMAL = 2'd0,
      ST_LOW    = 2'd1,
      ST_CRIT   = 2'd2,
      ST_EMPTY  = 2'd3
   } state_t;

   localparam int unsigned CNT_W   = $clog2(DEBOUNCE + 1);
   localparam int unsigned BLINK_W = $clog2(BLINK_HALF + 1);
   localparam logic [4:0]  LOW_L   = 5'(LOW_LEVEL);
   localparam logic [4:0]  CRIT_L  = 5'(CRIT_LEVEL);
   localparam logic [4:0]  HYST_L  = 5'(HYST);

   state_t               r_state, r_cand;
   logic [CNT_W-1:0]     r_cnt;
   logic [BLINK_W-1:0]   r_blink;
   logic                 r_warn, r_crit, r_buz;
   logic [7:0]           r_alert;

   state_t               w_raw, w_raw_h, w_cls;
   state_t               w_state_n, w_cand_n;
   logic [CNT_W-1:0]     w_cnt_n;
   logic [BLINK_W-1:0]   w_blink_n, w_blink_inc;
   logic                 w_enter, w_warn_n, w_crit_n, w_buz_n;
   logic [7:0]           w_alert_n;

   function automatic state_t classify(input logic [4:0] f);
      if (f == 5'd0)         return ST_EMPTY;
      else if (f <= CRIT_L)  return ST_CRIT;
      else if (f <= LOW_L)   return ST_LOW;
      else                   return ST_NORMAL;
   endfunction

   function automatic logic [4:0] sat_sub(input logic [4:0] f);
      return (f > HYST_L) ? (f - HYST_L) : 5'd0;
   endfunction

   // Improvement is judged against thresholds shifted by HYST and never overshoots the current level
   always_comb begin
      w_raw   = classify(bus.remaining_fuel);
      w_raw_h = classify(sat_sub(bus.remaining_fuel));
      if (w_raw >= r_state)       w_cls = w_raw;
      else if (w_raw_h > r_state) w_cls = r_state;
      else                        w_cls = w_raw_h;
   end

   always_comb begin
      w_state_n   = r_state;
      w_cand_n    = r_cand;
      w_cnt_n     = r_cnt;
      w_blink_n   = '0;
      w_blink_inc = r_blink + BLINK_W'(1);
      w_buz_n     = r_buz;
      w_alert_n   = r_alert;

      if (bus.sample_valid) begin
         if (w_cls == r_state) begin
            w_cnt_n = '0;
         end else if (w_cls == r_cand) begin
            w_cnt_n = r_cnt + CNT_W'(1);
         end else begin
            w_cand_n = w_cls;
            w_cnt_n  = CNT_W'(1);
         end
         if (w_cnt_n == CNT_W'(DEBOUNCE)) begin
            w_state_n = w_cand_n;
            w_cnt_n   = '0;
         end
      end

      w_enter  = (w_state_n != r_state);
      w_warn_n = (w_state_n == ST_LOW);
      w_crit_n = (w_state_n == ST_CRIT);

      // Blink phase restarts lit on every entry into EMPTY
      if (w_state_n == ST_EMPTY) begin
         if (w_enter) begin
            w_crit_n = 1'b1;
         end else if (w_blink_inc == BLINK_W'(BLINK_HALF)) begin
            w_crit_n = ~r_crit;
         end else begin
            w_crit_n  = r_crit;
            w_blink_n = w_blink_inc;
         end
      end

      // A new escalation outranks a simultaneous acknowledge
      if (w_enter && (w_state_n > r_state) && (w_state_n >= ST_CRIT))
         w_buz_n = 1'b1;
      else if (bus.ack || (w_enter && (w_state_n <= ST_LOW)))
         w_buz_n = 1'b0;

      if (w_enter && (r_state <= ST_LOW) && (w_state_n >= ST_CRIT) && (r_alert != 8'hFF))
         w_alert_n = r_alert + 8'd1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_NORMAL;
         r_cand  <= ST_NORMAL;
         r_cnt   <= '0;
         r_blink <= '0;
         r_warn  <= 1'b0;
         r_crit  <= 1'b0;
         r_buz   <= 1'b0;
         r_alert <= 8'd0;
      end else begin
         r_state <= w_state_n;
         r_cand  <= w_cand_n;
         r_cnt   <= w_cnt_n;
         r_blink <= w_blink_n;
         r_warn  <= w_warn_n;
         r_crit  <= w_crit_n;
         r_buz   <= w_buz_n;
         r_alert <= w_alert_n;
      end
   end

   assign bus.state       = r_state;
   assign bus.warn_led    = r_warn;
   assign bus.crit_led    = r_crit;
   assign bus.buzzer      = r_buz;
   assign bus.alert_count = r_alert;

endmodule

// File: doc/fuel_alert_controller.md
# fuel_alert_controller

Consumes the per-cycle remaining-fuel value produced by the digital fuel gauge stage and turns it into debounced, hysteretic driver alerts. It classifies fuel into four severity levels, debounces level changes over consecutive samples, and drives a warning LED, a critical/empty LED with blink, and a latched buzzer that the driver can acknowledge. It also keeps a saturating count of critical-alert entries for the trip log.

## Interface
- `LOW_LEVEL`, 5: fuel at or below this level, and above `CRIT_LEVEL`, is LOW.
- `CRIT_LEVEL`, 2: fuel at or below this level, and above 0, is CRITICAL.
- `HYST`, 1: margin that fuel must exceed a threshold by before the state may improve.
- `DEBOUNCE`, 4: consecutive valid samples needed to change state (≥1).
- `BLINK_HALF`, 8: clock cycles per half-period of the EMPTY blink (≥1).

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `sample_valid`  in  1  `remaining_fuel` is a new sample this cycle.
- `remaining_fuel`  in  5  fuel in litres from the gauge stage, unsigned.
- `ack`  in  1  driver acknowledge pulse; silences the buzzer.
- `state`  out  2  current level: 0 NORMAL, 1 LOW, 2 CRITICAL, 3 EMPTY.
- `warn_led`  out  1  high while the state is LOW.
- `crit_led`  out  1  steady high in CRITICAL; blinking in EMPTY.
- `buzzer`  out  1  latched audible alert.
- `alert_count`  out  8  number of entries into CRITICAL/EMPTY from NORMAL/LOW; saturates at 255.

## Operation
- Raw classification `raw(f)`:
  - EMPTY if f == 0.
  - CRITICAL if 0 < f ≤ CRIT_LEVEL.
  - LOW if CRIT_LEVEL < f ≤ LOW_LEVEL.
  - NORMAL otherwise.
- Hysteresis when the sample's class `cls` is derived:
  - If `raw(f)` is equal to or more severe than `state`, then `cls = raw(f)`. Worsening uses the plain thresholds.
  - Otherwise `cls = raw(f ⊖ HYST)`, where ⊖ is saturating subtract at 0. The result is clamped so it is never more severe than `state`.
- Debounce applies only to cycles with `sample_valid=1`; cycles without it are ignored and hold all counters. The block keeps a candidate level `cand` and a counter `cnt`:
  - `cls == state`: clear `cnt`.
  - `cls != state` and `cls == cand`: increment `cnt`.
  - `cls != state` and `cls != cand`: set `cand = cls` and `cnt = 1`.
  - When `cnt` reaches DEBOUNCE: set `state = cand` and clear `cnt`.
- Direct jumps are allowed, e.g. NORMAL→EMPTY or EMPTY→NORMAL.
- LEDs:
  - `warn_led = (state==LOW)`.
  - In CRITICAL, `crit_led` is steady 1.
  - In EMPTY, `crit_led` starts at 1 on entry and toggles every BLINK_HALF cycles. The blink counter runs every cycle, regardless of `sample_valid`, and resets on each entry to EMPTY.
  - In NORMAL and LOW, `crit_led` is 0.
- Buzzer:
  - Set on any transition into a more severe state that is CRITICAL or EMPTY. This includes CRITICAL→EMPTY.
  - Cleared by `ack=1`, or by a transition to NORMAL or LOW.
  - `ack` while the buzzer is low has no effect and is not remembered.
  - If a set and `ack` occur in the same cycle, the set wins.
- `alert_count` increments by 1 on each transition from NORMAL/LOW into CRITICAL/EMPTY. It does not increment on CRITICAL→EMPTY. It holds at 255.

## Timing
- All outputs are registered; there are no combinational input→output paths.
- Reset values: `state`=NORMAL (0), `warn_led`=0, `crit_led`=0, `buzzer`=0, `alert_count`=0. Internal `cand`, `cnt` and the blink counter are also cleared.
- Reset asserted mid-debounce discards all progress. After release, DEBOUNCE fresh samples are required.
- State-change latency: `state`, the LEDs, `buzzer` and `alert_count` all update on the same rising edge that accepts the DEBOUNCE-th qualifying sample.
- `ack` takes effect on the edge where it is sampled high. `buzzer` reads 0 from the following cycle.
- First blink toggle in EMPTY occurs BLINK_HALF cycles after the entry edge.

## Test plan
- Debounce: after reset, drive `remaining_fuel`=4 with `sample_valid` on 4 consecutive samples → `state`=1 and `warn_led`=1 on the 4th sample's edge. Separately, three samples of 4 then one of 10 → `state` stays 0.
- Hysteresis: in LOW, four samples of 6 → `state` stays 1. Then four samples of 7 → `state`=0 and `warn_led`=0.
- Empty path: from NORMAL, four samples of 0 → `state`=3, `buzzer`=1, `alert_count`=1, `crit_led`=1. `crit_led` toggles every 8 cycles. An `ack` pulse → `buzzer`=0 next cycle while blinking continues.
- Escalation and race: CRITICAL (`alert_count`=1) → four samples of 0 with `ack` high on the 4th sample's cycle → `state`=3, `buzzer`=1, `alert_count` still 1.
- Reset mid-operation: three samples of 1, pull `reset` low, release, then one sample of 1 → `state`=0. Three further samples of 1 → `state`=2.
- Saturation and gaps: alternate 4×(fuel 9) / 4×(fuel 1) for 300 cycles of entry, with idle cycles between samples → `alert_count` ends at 255, and idle cycles never break a debounce run.
